// File: rtl/keypad_pkg.sv
// Shared types and constants for the 3x4 keypad scanner: scan states, special
// key codes and the key-map-position to key-code table.
package keypad_pkg;

    typedef enum logic [1:0] {COL0, COL1, COL2, EVAL} state_t;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    // Indexed by col*4 + row
    localparam logic [3:0] KEY_CODES [0:11] = '{
        4'h1, 4'h4, 4'h7, KEY_STAR,
        4'h2, 4'h5, 4'h8, 4'h0,
        4'h3, 4'h6, 4'h9, KEY_HASH
    };

endpackage

// File: rtl/keypad_debounce.sv
// Accepts a scan code only after DB_SCANS consecutive identical scans; emits a
// one-cycle press pulse whenever a real key (not KEY_NONE) is accepted.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw,
    input  logic       eval,
    output logic [3:0] val,
    output logic       press
);

    localparam int unsigned CW = $clog2(DB_SCANS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_SCANS);

    logic [3:0]    cand, cand_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          accept;

    always_comb begin
        cand_next = cand;
        cnt_next  = cnt;
        if (raw == cand) begin
            cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
        end else begin
            cand_next = raw;
            cnt_next  = CW'(1);
        end
        // Decide on the post-update values so val changes right after EVAL
        accept = eval && (cnt_next == CNT_MAX) && (cand_next != val);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand  <= KEY_NONE;
            cnt   <= '0;
            val   <= KEY_NONE;
            press <= 1'b0;
        end else begin
            if (eval) begin
                cand <= cand_next;
                cnt  <= cnt_next;
            end
            if (accept) begin
                val <= cand_next;
            end
            press <= accept && (cand_next != KEY_NONE);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 3-column x 4-row keypad scanner: drives one column at a time, samples the
// synchronized rows into a key map, and turns a single-key map into a code.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned COL_TICKS = 50000,
    parameter int unsigned DB_SCANS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [2:0] cols,
    output logic [3:0] val,
    output logic       press
);

    localparam int unsigned DW = $clog2(COL_TICKS) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(COL_TICKS - 1);

    state_t      state;
    logic [DW-1:0] dwell;
    logic [11:0] keymap;
    logic [3:0]  rows_s1, rows_s2;
    logic [3:0]  raw;
    logic [3:0]  hits;
    logic [3:0]  hit_idx;
    logic        last_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_s1 <= '0;
            rows_s2 <= '0;
        end else begin
            rows_s1 <= rows;
            rows_s2 <= rows_s1;
        end
    end

    assign last_tick = (dwell == DWELL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= COL0;
            dwell  <= '0;
            cols   <= 3'b001;
            keymap <= '0;
        end else begin
            unique case (state)
                COL0: begin
                    if (last_tick) begin
                        keymap[3:0] <= rows_s2;
                        state       <= COL1;
                        cols        <= 3'b010;
                        dwell       <= '0;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                COL1: begin
                    if (last_tick) begin
                        keymap[7:4] <= rows_s2;
                        state       <= COL2;
                        cols        <= 3'b100;
                        dwell       <= '0;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                COL2: begin
                    if (last_tick) begin
                        keymap[11:8] <= rows_s2;
                        state        <= EVAL;
                        dwell        <= '0;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                EVAL: begin
                    state <= COL0;
                    cols  <= 3'b001;
                    dwell <= '0;
                end
                default: begin
                    state <= COL0;
                    cols  <= 3'b001;
                    dwell <= '0;
                end
            endcase
        end
    end

    // Anything other than exactly one closed switch reads as no key
    always_comb begin
        hits    = '0;
        hit_idx = '0;
        for (int i = 0; i < 12; i++) begin
            if (keymap[i]) begin
                hits    = hits + 1'b1;
                hit_idx = 4'(i);
            end
        end
        raw = (hits == 4'd1) ? KEY_CODES[hit_idx] : KEY_NONE;
    end

    keypad_debounce #(
        .DB_SCANS(DB_SCANS)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw),
        .eval (state == EVAL),
        .val  (val),
        .press(press)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with COL_TICKS=4, DB_SCANS=2 (13-cycle scan);
// a keypad model closes rows from the driven column and the pressed-key set.
module tb_keypad_scan;

    logic       clk;
    logic       rst;
    logic [3:0] rows;
    logic [2:0] cols;
    logic [3:0] val;
    logic       press;

    // Pressed keys, indexed col*4 + row
    logic [11:0] pressed;
    int checks;
    int errors;
    int press_cnt;

    keypad_scan #(
        .COL_TICKS(4),
        .DB_SCANS (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rows (rows),
        .cols (cols),
        .val  (val),
        .press(press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[c*4 + r] && cols[c]) rows[r] = 1'b1;
            end
        end
    end

    // Every cycle is observed exactly once, so press pulses are counted here
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (press === 1'b1) press_cnt++;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        press_cnt = 0;
    endtask

    task automatic chk_val(input string name, input logic [3:0] exp);
        checks++;
        if (val !== exp) begin
            errors++;
            $display("FAIL %s: val=%h expected %h at %0t", name, val, exp, $time);
        end
    endtask

    task automatic test_reset();
        pressed = '0;
        rst = 1'b1;
        #1;
        checks++;
        if (cols !== 3'b001 || val !== 4'hF || press !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: cols=%b val=%h press=%b expected 001 f 0",
                     cols, val, press);
        end
        apply_reset();
    endtask

    task automatic test_idle_scan();
        pressed = '0;
        apply_reset();
        checks++;
        if (cols !== 3'b001) begin errors++; $display("FAIL idle_col0: cols=%b expected 001", cols); end
        tick(4);
        checks++;
        if (cols !== 3'b010) begin errors++; $display("FAIL idle_col1: cols=%b expected 010", cols); end
        tick(4);
        checks++;
        if (cols !== 3'b100) begin errors++; $display("FAIL idle_col2: cols=%b expected 100", cols); end
        tick(4);
        checks++;
        if (cols !== 3'b100) begin errors++; $display("FAIL idle_eval: cols=%b expected 100", cols); end
        tick(1);
        checks++;
        if (cols !== 3'b001) begin errors++; $display("FAIL idle_wrap: cols=%b expected 001", cols); end
        tick(26);
        chk_val("idle_val", 4'hF);
        checks++;
        if (press_cnt !== 0) begin errors++; $display("FAIL idle_press: pulses=%0d expected 0", press_cnt); end
    endtask

    task automatic test_hold();
        pressed = '0;
        pressed[1*4 + 1] = 1'b1;  // key 5
        apply_reset();
        tick(25);
        chk_val("hold_before_2nd_eval", 4'hF);
        tick(1);
        chk_val("hold_accept", 4'h5);
        checks++;
        if (press !== 1'b1) begin errors++; $display("FAIL hold_press_pulse: press=%b expected 1", press); end
        tick(1);
        checks++;
        if (press !== 1'b0) begin errors++; $display("FAIL hold_press_width: press=%b expected 0", press); end
        tick(130);
        chk_val("hold_10_scans", 4'h5);
        checks++;
        if (press_cnt !== 1) begin errors++; $display("FAIL hold_press_count: pulses=%0d expected 1", press_cnt); end
        pressed = '0;
    endtask

    task automatic test_bounce();
        pressed = '0;
        pressed[2*4 + 3] = 1'b1;  // key #
        apply_reset();
        tick(13);
        pressed = '0;
        chk_val("bounce_after_1_scan", 4'hF);
        tick(65);
        chk_val("bounce_final", 4'hF);
        checks++;
        if (press_cnt !== 0) begin errors++; $display("FAIL bounce_press: pulses=%0d expected 0", press_cnt); end
    endtask

    task automatic test_multi_key();
        pressed = '0;
        pressed[0*4 + 3] = 1'b1;  // *
        pressed[2*4 + 2] = 1'b1;  // 9
        apply_reset();
        tick(65);
        chk_val("multi_key", 4'hF);
        checks++;
        if (press_cnt !== 0) begin errors++; $display("FAIL multi_press: pulses=%0d expected 0", press_cnt); end
        pressed = '0;
    endtask

    task automatic test_direct_change();
        pressed = '0;
        pressed[0*4 + 0] = 1'b1;  // key 1
        apply_reset();
        tick(26);
        chk_val("change_first", 4'h1);
        pressed = '0;
        pressed[1*4 + 3] = 1'b1;  // key 0
        tick(25);
        chk_val("change_before", 4'h1);
        tick(1);
        chk_val("change_to_0", 4'h0);
        checks++;
        if (press !== 1'b1 || press_cnt !== 2) begin
            errors++;
            $display("FAIL change_press: press=%b pulses=%0d expected 1 and 2", press, press_cnt);
        end
        pressed = '0;
        tick(25);
        chk_val("release_before", 4'h0);
        tick(1);
        chk_val("release_none", 4'hF);
        checks++;
        if (press !== 1'b0 || press_cnt !== 2) begin
            errors++;
            $display("FAIL release_press: press=%b pulses=%0d expected 0 and 2", press, press_cnt);
        end
    endtask

    task automatic test_reset_mid_debounce();
        pressed = '0;
        pressed[0*4 + 2] = 1'b1;  // key 7
        apply_reset();
        tick(17);  // one EVAL done, now in COL1
        rst = 1'b1;
        #1;
        checks++;
        if (cols !== 3'b001 || val !== 4'hF || press !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: cols=%b val=%h press=%b expected 001 f 0",
                     cols, val, press);
        end
        @(negedge clk);
        rst = 1'b0;
        press_cnt = 0;
        tick(13);
        chk_val("midreset_1_scan", 4'hF);
        tick(12);
        chk_val("midreset_before_2nd", 4'hF);
        tick(1);
        chk_val("midreset_accept", 4'h7);
        checks++;
        if (press_cnt !== 1) begin errors++; $display("FAIL midreset_press: pulses=%0d expected 1", press_cnt); end
        pressed = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        press_cnt = 0;
        pressed = '0;
        rst = 1'b1;
        test_reset();
        test_idle_scan();
        test_hold();
        test_bounce();
        test_multi_key();
        test_direct_change();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter COL_TICKS, default 50000, gives the number of clk cycles each column is driven per scan.
REQ-002 Parameter DB_SCANS, default 4, gives the number of consecutive identical full scans required to accept a code change.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rows  input  4  keypad row lines; active-high; rows[0] is the top row; asynchronous to clk.
REQ-006 cols  output  3  keypad column drive; one-hot, active-high; cols[0] is the left column (1,4,7,*).
REQ-007 val  output  4  debounced key code, held stable between changes: 0-9 digits, 4'hA = *, 4'hB = #, 4'hF = no key; feeds the seven-segment decoder input directly.
REQ-008 press  output  1  single-cycle pulse in the cycle val changes to a code other than 4'hF.

Function
REQ-009 rows shall pass through a 2-flop synchronizer before any use; this adds 2 cycles of input latency.
REQ-010 The FSM shall have states COL0, COL1, COL2 and EVAL, with cols = 001, 010, 100 in COL0-COL2 and cols = 100 held in EVAL.
REQ-011 Each COLn state shall last exactly COL_TICKS cycles, counted by a dwell counter cleared on every state entry.
REQ-012 Synchronized rows shall be sampled only in the last dwell cycle of each COLn, into a 12-bit key map (3 cols x 4 rows).
REQ-013 EVAL shall last 1 cycle and then go to COL0; one full scan shall therefore take 3*COL_TICKS+1 cycles.
REQ-014 In EVAL, a raw scan code shall be formed from the key map: exactly one bit set gives that key's code; zero bits or two or more bits give 4'hF (multi-key presses are rejected).
REQ-015 Key map to code: col0 rows 0-3 = 1, 4, 7, A; col1 = 2, 5, 8, 0; col2 = 3, 6, 9, B.
REQ-016 Debounce: a candidate register and match counter shall update in EVAL; a raw code equal to the candidate increments the counter (saturating at DB_SCANS); a differing raw code loads the candidate and sets the counter to 1.
REQ-017 When the counter reaches DB_SCANS and the candidate differs from val, val shall load the candidate in the cycle after EVAL.
REQ-018 press shall assert for exactly that one cycle when the new val is not 4'hF; no pulse on release.
REQ-019 A held key shall produce exactly one press pulse for any hold duration.
REQ-020 A direct change from key X to key Y without an intervening release shall update val to Y and pulse press once, after DB_SCANS scans of Y.
REQ-021 Release shall set val to 4'hF only after DB_SCANS consecutive no-key scans.
REQ-022 A bounce (a differing code for fewer than DB_SCANS scans) shall leave val unchanged and restart the candidate count.
REQ-023 Counter widths shall be $clog2 of their maximum value plus 1; counters shall never wrap.

Reset
REQ-024 rst shall asynchronously force state COL0, dwell counter 0, cols = 001, key map 0, candidate 4'hF, match count 0, synchronizer flops 0, val = 4'hF and press = 0.
REQ-025 rst asserted mid-scan or mid-debounce shall discard all partial results; after release, the first accepted key shall again require DB_SCANS full scans.

Structure
REQ-026 A package keypad_pkg shall hold the state enum (COL0, COL1, COL2, EVAL), KEY_NONE = 4'hF, KEY_STAR = 4'hA, KEY_HASH = 4'hB and the 12-entry map-to-code table.
REQ-027 The candidate/match-count/val/press logic shall be a sub-module keypad_debounce with inputs raw code and EVAL strobe, and outputs val and press.
REQ-028 Scan FSM, dwell counter, synchronizer and map-to-code logic shall be in keypad_scan.

Verification (COL_TICKS = 4, DB_SCANS = 2, scan = 13 cycles; a keypad model drives rows from cols)
REQ-029 Reset release with no key held -> cols cycles 001/010/100 every 4 cycles; val stays 4'hF; press never asserts.
REQ-030 Key 5 held continuously -> val = 4'h5 after the 2nd EVAL; exactly one press pulse; val stays 5 for 10 scans.
REQ-031 # held for 1 scan only, then released -> val remains 4'hF; no press pulse.
REQ-032 * and 9 held simultaneously for 5 scans -> val remains 4'hF; no press.
REQ-033 Key 1 accepted, then switched directly to 0 -> val goes to 4'h0 after 2 scans with a second press pulse; release then gives val = 4'hF after 2 scans with no pulse.
REQ-034 rst pulsed in COL1 while key 7 is mid-debounce (count 1) -> all outputs return to reset values; val = 4'h7 only after 2 further full scans.
